// File: rtl/div32_seq.sv
// Iterative restoring radix-2 divider, one quotient bit per clock.
// LO = quotient, HI = remainder; signed mode truncates toward zero.
module div32_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DIV_BY_ZERO,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_r;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_sa;
    logic                  r_sb;
    logic                  r_dz;

    logic                  w_sa;
    logic                  w_sb;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_b_zero;
    logic [DATA_WIDTH:0]   w_shift;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_sub;

    // Operand magnitudes and one restoring step
    always_comb begin
        w_sa     = SIGNED & A[DATA_WIDTH-1];
        w_sb     = SIGNED & B[DATA_WIDTH-1];
        w_a_mag  = w_sa ? -A : A;
        w_b_mag  = w_sb ? -B : B;
        w_b_zero = (B == '0);
        w_shift  = {r_r, r_q[DATA_WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_b});
        w_sub    = DATA_WIDTH'(w_shift - {1'b0, r_b});
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_b         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_dz        <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_r   <= '0;
                        r_cnt <= CNT_W'(DATA_WIDTH);
                        BUSY  <= 1'b1;
                        // Zero divisor keeps the raw dividend for HI and skips iteration
                        if (w_b_zero) begin
                            r_q     <= A;
                            r_b     <= '0;
                            r_sa    <= 1'b0;
                            r_sb    <= 1'b0;
                            r_dz    <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_q     <= w_a_mag;
                            r_b     <= w_b_mag;
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
                            r_dz    <= 1'b0;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_r   <= w_ge ? w_sub : w_shift[DATA_WIDTH-1:0];
                    r_q   <= {r_q[DATA_WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        LO <= '1;
                        HI <= r_q;
                    end else begin
                        LO <= (r_sa ^ r_sb) ? -r_q : r_q;
                        HI <= r_sa ? -r_r : r_r;
                    end
                    DIV_BY_ZERO <= r_dz;
                    DONE        <= 1'b1;
                    BUSY        <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32-bit divider. It is the inverse companion of the combinational multipliers and uses the same HI/LO result convention.
- Supports signed and unsigned division, restoring radix-2, one quotient bit per clock.
- LO carries the quotient and HI carries the remainder, matching MIPS DIV/DIVU semantics.
- Sits beside the ALU; the control unit stalls on BUSY and captures HI/LO on DONE.

Parameters:
DATA_WIDTH, 32, operand/result width (equals `DATA_INDEX_LIMIT+1); iteration count equals DATA_WIDTH

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset; synchronous and active-low
START  input  1  request; sampled only while BUSY=0
SIGNED  input  1  1 = two's-complement divide, 0 = unsigned; sampled with START
A  input  32  dividend; sampled with START
B  input  32  divisor; sampled with START
BUSY  output  1  high from the edge that accepts START until the edge that asserts DONE
DONE  output  1  one-cycle pulse; HI/LO/DIV_BY_ZERO valid in that cycle
DIV_BY_ZERO  output  1  set with DONE when B==0; held until next DONE
HI  output  32  remainder; held until next DONE
LO  output  32  quotient; held until next DONE

Behaviour:
- Reset (RST=0 at rising edge): state IDLE; BUSY=0, DONE=0, DIV_BY_ZERO=0, HI=0, LO=0; internal counter/accumulators cleared. Reset overrides START and aborts any operation in flight.
- States: IDLE, ITER, FIX.
- IDLE:
  - START=1 at edge e0: latch sign flags (SIGNED & A[31], SIGNED & B[31]) and the magnitudes |A|, |B| as 32-bit unsigned. |0x80000000| = 0x80000000.
  - Clear remainder accumulator R (33 bits); load counter = 32; BUSY<=1; next state ITER.
  - If B==0 at e0: next state FIX directly with the zero flag set; no iterations.
- ITER, one step per edge e1..e32:
  - R = {R[31:0], Q[31]}; Q = Q<<1.
  - If R >= |B|: R = R - |B|, Q[0] = 1.
  - Decrement counter; at counter reaching 0, next state FIX.
- FIX (edge e33 for normal divides, e1 for divide-by-zero):
  - LO <= quotient sign ? -Q : Q, where quotient sign = sA XOR sB.
  - HI <= sA ? -R[31:0] : R[31:0].
  - DONE<=1 for exactly one cycle; BUSY<=0; state IDLE.
  - DIV_BY_ZERO<=(B==0 latched).
- Latency: DONE is high in the cycle after edge e33, i.e. 33 clocks after the START-accepting edge. Divide-by-zero: DONE after 1 clock.
- Divide by zero: LO=0xFFFFFFFF, HI=A (original dividend, unmodified), DIV_BY_ZERO=1, for both signed and unsigned.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend; invariant A == LO*B + HI (mod 2^32).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, DIV_BY_ZERO=0. This is the natural wrap result, not an error.
- START while BUSY=1: ignored; operands are not resampled and the in-flight operation is unaffected.
- START in the same cycle DONE is high: BUSY is already 0, so the request is accepted (back-to-back operation allowed).
- DIV_BY_ZERO clears on the next DONE of a nonzero-divisor operation.
- A/B/SIGNED may change freely after the accepting edge.

Test Plan:
1. Unsigned: SIGNED=0, A=200, B=10, START pulse -> BUSY=1 for 33 cycles; DONE pulse with LO=0x00000014, HI=0; DIV_BY_ZERO=0. Also A=0xFFFFFFFF, B=0x10 -> LO=0x0FFFFFFF, HI=0xF.
2. Signed sign combinations:
   - A=-45, B=7 -> LO=0xFFFFFFFA, HI=0xFFFFFFFD.
   - A=45, B=-7 -> LO=0xFFFFFFFA, HI=3.
   - A=-45, B=-7 -> LO=6, HI=0xFFFFFFFD.
   - Unsigned A=0x90000000, B=0x70000000 -> LO=1, HI=0x20000000.
3. Divide by zero: A=0x12345678, B=0, SIGNED=1 -> DONE one cycle after accept, LO=0xFFFFFFFF, HI=0x12345678, DIV_BY_ZERO=1. Follow with 10/3 -> DIV_BY_ZERO=0, LO=3, HI=1.
4. Overflow/corner: signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Unsigned 0x80000000 / 1 -> LO=0x80000000, HI=0.
5. Protocol: start 100/7; raise START with A=1, B=1 at cycle 10 -> ignored, result LO=14, HI=2. Assert START with 9/2 during the DONE cycle -> accepted, DONE 33 cycles later with LO=4, HI=1.
6. Reset mid-operation: start 1000/3; drive RST=0 at cycle 15 for one edge -> BUSY=0, DONE=0, HI=LO=0, no DONE pulse follows. A subsequent 1000/3 yields LO=333, HI=1.
